div_result_disp: RTL
====================

Name: div_result_disp

Overview:
Downstream stage of the 8/4 sequential divider. It watches the divider's ready line, captures quotient and remainder when a division completes, and converts each 4-bit value to two BCD digits with a sequential double-dabble (shift-add-3). It then drives a 4-digit multiplexed common-anode seven-segment display: QQ on the left, RR on the right. It also presents the packed BCD result and a one-cycle done pulse for other consumers.

Parameters:
SCAN_BITS, 16, width of the display scan prescaler; the active digit advances every 2^SCAN_BITS clk cycles (benches use 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
quotient  input  4  divider quotient, valid while ready=1
remainder  input  4  divider remainder, valid while ready=1
ready  input  1  divider idle/result-valid flag (low while dividing)
bcd  output  16  {Q tens, Q ones, R tens, R ones}, one nibble each
done  output  1  one-cycle pulse when bcd/display are updated
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit anodes, active-low, one-hot-low

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready_d=1, bcd=16'hFFFF (blank code), done=0
  - scan counter=0, digit index=0, an=4'b1110, seg=7'b1111111
- Completion detect: rise = ready & ~ready_d, with ready_d registered every cycle.
  - ready_d resets to 1, so the ready rise caused by reset release is NOT treated as a result.
- FSM states:
  - IDLE: on rise, capture {quotient, remainder} into the working shift registers, clear the BCD accumulators, iteration count=3, go to CONV.
  - CONV: one double-dabble iteration per cycle, applied to Q and R in parallel.
    - Each iteration: if the ones nibble >=5, add 3 to it; then shift {tens, ones, src} left by 1.
    - After the count==0 iteration, go to LOAD.
  - LOAD: bcd <= result, done=1 for exactly this cycle, go to IDLE.
- Latency: rise sampled at edge E0 (capture); CONV iterations on E1..E4; LOAD entered at E4. done is high and bcd is valid in the cycle after E4, and bcd holds until the next LOAD.
- Tens digit range is 0..1 for both values; ones is 0..9. The tens nibble is stored 4 bits wide, upper bits 0.
- A rise during CONV or LOAD is ignored. This cannot occur with a 5-cycle divider and is not queued.
- A new division (ready falls) does not blank the display; the old result is shown until LOAD.
- Scan:
  - Prescaler increments every cycle.
  - On wrap to 0, digit index advances 0→1→2→3→0.
  - an is active-low one-hot: index 0 → an=1110 shows bcd[3:0]; index 3 → an=0111 shows bcd[15:12].
  - seg and an update in the same cycle (registered together); no ghosting cycle.
- Segment decode, active-low, order gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble A–F = 1111111 (blank)
- Reset mid-CONV: conversion abandoned, bcd returns to FFFF, display blanks, done stays 0.

Test Plan:
- Reset, release with ready rising 0→1 → no done pulse; bcd=16'hFFFF, seg=7'b1111111 on all four digits.
- quotient=14, remainder=2, ready 1→0→1 → done pulses exactly 5 cycles after the rise edge, one cycle wide; bcd=16'h1402.
- SCAN_BITS=2 after 14 r 2 → an cycles 1110,1101,1011,0111 every 4 clk. seg is 0100100 for digit 0 (remainder ones = 2), then 1000000 (remainder tens = 0), 0011001 (quotient ones = 4), 1111001 (quotient tens = 1).
- Boundary values:
  - quotient=15, remainder=9 → bcd=16'h1509.
  - Then quotient=0, remainder=0 → bcd=16'h0000, done pulse each time.
- Second ready rise forced 2 cycles after the first → ignored. Exactly one done pulse, with bcd matching the first captured operands.
- Assert reset during CONV (2 cycles after rise) → bcd=16'hFFFF, an=1110, done never pulses; a later rise converts normally.

Source files
------------

// File: rtl/div_result_disp.sv
// Result stage for the 8/4 sequential divider: captures Q/R on the ready rise, converts each
// value to two BCD digits with a per-lane double-dabble, and scans a 4-digit common-anode display.
module div_result_disp #(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  quotient,
  input  logic [3:0]  remainder,
  input  logic        ready,
  output logic [15:0] bcd,
  output logic        done,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int NUM_LANES = 2;  // lane 1 = quotient, lane 0 = remainder

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t state_q, state_d;
  logic   rdy_q, rise;
  logic [1:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0][3:0] src_q, src_d, src_nx;
  logic [NUM_LANES-1:0][3:0] ones_q, ones_d, ones_nx, ones_adj;
  // A 4-bit value never exceeds 15, so the tens digit is a single bit per lane.
  logic [NUM_LANES-1:0]      tens_q, tens_d, tens_nx;
  logic [15:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  logic [SCAN_BITS-1:0] scan_q;
  logic [1:0] dig_q, dig_d;
  logic [3:0] an_q, nib;
  logic [6:0] seg_q;

  assign rise = ready & ~rdy_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign ones_adj[g] = (ones_q[g] >= 4'd5) ? ones_q[g] + 4'd3 : ones_q[g];
    assign tens_nx[g]  = ones_adj[g][3];
    assign ones_nx[g]  = {ones_adj[g][2:0], src_q[g][3]};
    assign src_nx[g]   = {src_q[g][2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        src_d   = {quotient, remainder};
        ones_d  = '0;
        tens_d  = '0;
        cnt_d   = 2'd3;
        state_d = CONV;
      end
      CONV: begin
        src_d  = src_nx;
        ones_d = ones_nx;
        tens_d = tens_nx;
        cnt_d  = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          // Publish on the last iteration edge so bcd and done appear together.
          bcd_d   = {3'b000, tens_nx[1], ones_nx[1], 3'b000, tens_nx[0], ones_nx[0]};
          done_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      src_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= 16'hFFFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= ready;
      src_q   <= src_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // an and seg are both derived from the next digit index so they switch on the same edge.
  assign dig_d = (scan_q == '1) ? dig_q + 2'd1 : dig_q;

  always_comb begin
    case (dig_d)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = bcd_q[15:12];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      dig_q  <= '0;
      an_q   <= 4'b1110;
      seg_q  <= 7'b1111111;
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
      dig_q  <= dig_d;
      an_q   <= ~(4'b0001 << dig_d);
      seg_q  <= seg_dec(nib);
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
